// File: rtl/cpu_1_ocimem_responder_pkg.sv
// Shared types and jdo field positions for the OCI memory responder.
package cpu_1_ocimem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_e;

  localparam int ADDR_LSB   = 26;
  localparam int WDATA_MSB  = 34;
  localparam int WDATA_LSB  = 3;
  localparam int RSTCLR_BIT = 24;
  localparam int MAX_ADDR_W = 8;

endpackage

// File: rtl/cpu_1_ocimem_responder_if.sv
// CPU-side slave bus onto the debug RAM; master drives requests, slave answers.
interface cpu_1_ocimem_responder_if #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );

endinterface

// File: rtl/cpu_1_ocimem_ram.sv
// Single-port synchronous debug RAM: registered address, data readable the cycle after.
module cpu_1_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       q_o
);

  logic [31:0]       mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;

  // read address register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_i;
    end
  end

  // storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign q_o = mem_q[addr_q];

endmodule

// File: rtl/cpu_1_ocimem_responder.sv
// JTAG OCI memory command responder with a CPU slave port sharing one debug RAM.
// Optional macro OCIMEM_WRITE_PROTECT_EN: upper RAM half is read-only from JTAG.
module cpu_1_ocimem_responder
  import cpu_1_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    jrst_n,
  input  logic [37:0]             jdo,
  input  logic                    take_action_ocimem_a,
  input  logic                    take_no_action_ocimem_a,
  input  logic                    take_action_ocimem_b,
  input  logic                    cpu_reset_seen,
  cpu_1_ocimem_responder_if.slave avs,
  output logic [31:0]             MonDReg,
  output logic                    monitor_ready,
  output logic                    monitor_error,
  output logic                    resetlatch,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              rstl_q, rstl_d;

  logic              any_strobe_s, multi_strobe_s;
  logic              do_a_s, do_na_s, do_b_s, wp_hit_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic              ram_we_s;
  logic [31:0]       ram_wdata_s, ram_q_s;
  logic              unused_jdo_s;

  assign any_strobe_s   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_strobe_s = (take_action_ocimem_a & take_no_action_ocimem_a) |
                          (take_action_ocimem_a & take_action_ocimem_b) |
                          (take_no_action_ocimem_a & take_action_ocimem_b);
  // Only one strobe executes per cycle: b beats no_action_a beats a.
  assign do_b_s  = (state_q == IDLE) & take_action_ocimem_b;
  assign do_na_s = (state_q == IDLE) & take_no_action_ocimem_a & ~take_action_ocimem_b;
  assign do_a_s  = (state_q == IDLE) & take_action_ocimem_a & ~take_no_action_ocimem_a &
                   ~take_action_ocimem_b;
`ifdef OCIMEM_WRITE_PROTECT_EN
  assign wp_hit_s = mon_a_q[ADDR_W-1];
`else
  assign wp_hit_s = 1'b0;
`endif
  assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

  assign avs.avs_waitrequest = (state_q != IDLE) | any_strobe_s;
  assign avs.avs_readdata    = ram_q_s;
  assign busy                = (state_q != IDLE);
  assign MonDReg             = mon_d_q;
  assign monitor_ready       = ready_q;
  assign monitor_error       = error_q;
  assign resetlatch          = rstl_q;

  cpu_1_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst_n   (jrst_n),
    .addr_i  (ram_addr_s),
    .we_i    (ram_we_s),
    .wdata_i (ram_wdata_s),
    .q_o     (ram_q_s)
  );

  // RAM port arbitration: JTAG strobes first, then an unstalled CPU request
  always_comb begin
    ram_addr_s  = mon_a_q;
    ram_we_s    = 1'b0;
    ram_wdata_s = jdo[WDATA_MSB:WDATA_LSB];
    if (do_b_s) begin
      ram_we_s = ~wp_hit_s;
    end else if (do_na_s) begin
      ram_addr_s = mon_a_q;
    end else if (!avs.avs_waitrequest && avs.avs_write) begin
      ram_addr_s  = avs.avs_address;
      ram_we_s    = 1'b1;
      ram_wdata_s = avs.avs_writedata;
    end else if (!avs.avs_waitrequest && avs.avs_read) begin
      ram_addr_s = avs.avs_address;
    end else begin
      ram_addr_s = mon_a_q;
    end
  end

  // state register
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = do_na_s ? RD : IDLE;
      RD:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // monitor register updates per state
  always_comb begin
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    ready_d = ready_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (do_b_s) begin
          mon_a_d = mon_a_q + ADDR_W'(1);
          ready_d = 1'b1;
          error_d = error_q | multi_strobe_s | wp_hit_s;
        end else if (do_na_s) begin
          mon_a_d = mon_a_q + ADDR_W'(1);
          ready_d = 1'b0;
          error_d = error_q | multi_strobe_s;
        end else if (do_a_s) begin
          mon_a_d = jdo[ADDR_LSB +: ADDR_W];
          ready_d = 1'b1;
          error_d = 1'b0;
        end else begin
          mon_a_d = mon_a_q;
        end
      end
      RD: begin
        mon_d_d = ram_q_s;
        ready_d = 1'b1;
        error_d = error_q | any_strobe_s;
      end
      default: begin
        mon_a_d = mon_a_q;
      end
    endcase
    // CPU reset indication outranks a clear request in the same cycle
    if (cpu_reset_seen) begin
      rstl_d = 1'b1;
    end else if (do_a_s && jdo[RSTCLR_BIT]) begin
      rstl_d = 1'b0;
    end else begin
      rstl_d = rstl_q;
    end
  end

  // monitor registers
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      mon_a_q <= '0;
      mon_d_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rstl_q  <= 1'b0;
    end else begin
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rstl_q  <= rstl_d;
    end
  end

endmodule

// File: tb/tb_cpu_1_ocimem_responder.sv
// Randomized self-checking bench: transaction-level model of debug RAM and monitor registers.
module tb_cpu_1_ocimem_responder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef OCIMEM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        jrst_n;
  logic [37:0] jdo;
  logic        take_a, take_na, take_b, cpu_reset_seen;
  logic [31:0] mon_d;
  logic        mon_ready, mon_error, rstlatch, busy;

  cpu_1_ocimem_responder_if #(.ADDR_W(ADDR_W)) avs_if ();

  cpu_1_ocimem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .jrst_n                  (jrst_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .cpu_reset_seen          (cpu_reset_seen),
    .avs                     (avs_if.slave),
    .MonDReg                 (mon_d),
    .monitor_ready           (mon_ready),
    .monitor_error           (mon_error),
    .resetlatch              (rstlatch),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_ram [DEPTH];
  int          m_a;
  logic [31:0] m_d;
  bit          m_err, m_rstl;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit jtag_ro(input int a);
    return WP && (a >= DEPTH / 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_reset_seen) m_rstl = 1'b1;
  endtask

  task automatic do_reset();
    jrst_n = 1'b0;
    tick();
    tick();
    m_a = 0; m_d = 32'h0; m_err = 1'b0; m_rstl = 1'b0;
    check_eq("rst_mondreg", mon_d, 32'h0);
    check_eq("rst_ready", mon_ready, 32'd0);
    check_eq("rst_error", mon_error, 32'd0);
    check_eq("rst_resetlatch", rstlatch, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_waitreq", avs_if.avs_waitrequest, 32'd0);
    jrst_n = 1'b1;
    tick();
  endtask

  task automatic jt_addr(input int a, input bit clr);
    jdo = '0;
    jdo[26 +: ADDR_W] = a[ADDR_W-1:0];
    jdo[24] = clr;
    take_a = 1'b1;
    #1 check_eq("strobe_waitreq", avs_if.avs_waitrequest, 32'd1);
    if (clr) m_rstl = 1'b0;
    tick();
    take_a = 1'b0;
    m_a = a; m_err = 1'b0;
    check_eq("addr_ready", mon_ready, 32'd1);
    check_eq("addr_error", mon_error, 32'd0);
    check_eq("addr_resetlatch", rstlatch, {31'd0, m_rstl});
  endtask

  task automatic jt_write(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
    if (jtag_ro(m_a)) m_err = 1'b1;
    else m_ram[m_a] = d;
    m_a = (m_a + 1) % DEPTH;
    check_eq("write_ready", mon_ready, 32'd1);
    check_eq("write_error", mon_error, {31'd0, m_err});
  endtask

  task automatic jt_read();
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    check_eq("read_busy", busy, 32'd1);
    check_eq("read_ready_low", mon_ready, 32'd0);
    tick();
    m_d = m_ram[m_a];
    m_a = (m_a + 1) % DEPTH;
    check_eq("read_ready", mon_ready, 32'd1);
    check_eq("read_mondreg", mon_d, m_d);
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d);
    avs_if.avs_address = a[ADDR_W-1:0];
    avs_if.avs_writedata = d;
    avs_if.avs_write = 1'b1;
    #1 check_eq("cpu_wr_waitreq", avs_if.avs_waitrequest, 32'd0);
    tick();
    avs_if.avs_write = 1'b0;
    m_ram[a] = d;
  endtask

  task automatic cpu_read(input int a);
    avs_if.avs_address = a[ADDR_W-1:0];
    avs_if.avs_read = 1'b1;
    tick();
    avs_if.avs_read = 1'b0;
    check_eq("cpu_readdata", avs_if.avs_readdata, m_ram[a]);
  endtask

  initial begin
    jdo = '0; take_a = 1'b0; take_na = 1'b0; take_b = 1'b0; cpu_reset_seen = 1'b0;
    avs_if.avs_address = '0; avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
    avs_if.avs_writedata = 32'h0;
    do_reset();

    for (int i = 0; i < DEPTH; i++) cpu_write(i, $urandom);

    // address load, write, read back through JTAG
    jt_addr(32'h10, 1'b0);
    jt_write(32'hDEAD_BEEF);
    jt_addr(32'h10, 1'b0);
    jt_read();
    jt_write(32'h1234_5678);
    cpu_read(32'h11);

    // address wrap at the top of the RAM
    jt_addr(DEPTH - 1, 1'b0);
    jt_write(32'hA5A5_0001);
    jt_write(32'h5A5A_0002);
    cpu_read(DEPTH - 1);
    cpu_read(0);

    // upper-half write (read-only from JTAG only when protection is built in)
    jt_addr(32'h80, 1'b0);
    jt_write(32'h0BAD_F00D);
    cpu_read(32'h80);
    cpu_write(32'h81, 32'h7777_8888);
    cpu_read(32'h81);

    // strobe during RD is dropped and flags an error
    jt_addr(32'h30, 1'b0);
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    jdo = '0;
    jdo[34:3] = 32'hCAFE_F00D;
    take_b = 1'b1;
    #1 check_eq("rd_collide_waitreq", avs_if.avs_waitrequest, 32'd1);
    tick();
    take_b = 1'b0;
    m_d = m_ram[32'h30]; m_a = 32'h31; m_err = 1'b1;
    check_eq("collide_mondreg", mon_d, m_d);
    check_eq("collide_error", mon_error, 32'd1);
    check_eq("collide_ready", mon_ready, 32'd1);
    cpu_read(32'h31);
    jt_addr(32'h31, 1'b0);

    // simultaneous strobes: write wins and error is raised
    jt_addr(32'h40, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'h1357_9BDF;
    take_a = 1'b1; take_b = 1'b1;
    tick();
    take_a = 1'b0; take_b = 1'b0;
    m_ram[32'h40] = 32'h1357_9BDF; m_a = 32'h41; m_err = 1'b1;
    check_eq("multi_error", mon_error, 32'd1);
    cpu_read(32'h40);
    jt_read();

    // CPU read stalled behind a JTAG read
    cpu_write(32'h20, 32'h2020_2020);
    jt_addr(32'h50, 1'b0);
    avs_if.avs_address = 8'h20;
    avs_if.avs_read = 1'b1;
    take_na = 1'b1;
    #1 check_eq("stall_strobe", avs_if.avs_waitrequest, 32'd1);
    tick();
    take_na = 1'b0;
    #1 check_eq("stall_rd", avs_if.avs_waitrequest, 32'd1);
    tick();
    check_eq("stall_released", avs_if.avs_waitrequest, 32'd0);
    tick();
    avs_if.avs_read = 1'b0;
    check_eq("stall_readdata", avs_if.avs_readdata, m_ram[32'h20]);
    check_eq("stall_mondreg", mon_d, m_ram[32'h50]);
    m_a = 32'h51;

    // reset latch: set, sticky, set beats clear, then clear
    cpu_reset_seen = 1'b1;
    tick();
    cpu_reset_seen = 1'b0;
    check_eq("rstl_set", rstlatch, 32'd1);
    tick();
    check_eq("rstl_sticky", rstlatch, 32'd1);
    cpu_reset_seen = 1'b1;
    jt_addr(32'h00, 1'b1);
    cpu_reset_seen = 1'b0;
    jt_addr(32'h00, 1'b1);

    // reset in the middle of a read
    jt_addr(32'h10, 1'b0);
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    jrst_n = 1'b0;
    #1;
    check_eq("midrd_busy", busy, 32'd0);
    check_eq("midrd_ready", mon_ready, 32'd0);
    check_eq("midrd_mondreg", mon_d, 32'h0);
    check_eq("midrd_waitreq", avs_if.avs_waitrequest, 32'd0);
    tick();
    jrst_n = 1'b1;
    m_a = 0; m_d = 32'h0; m_err = 1'b0; m_rstl = 1'b0;
    tick();
    jt_read();

    // randomized mix of JTAG and CPU transactions
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: jt_addr($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)));
        1: jt_write($urandom);
        2: jt_read();
        3: cpu_write($urandom_range(0, DEPTH - 1), $urandom);
        default: cpu_read($urandom_range(0, DEPTH - 1));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_1_ocimem_responder.md
Name: cpu_1_ocimem_responder

Overview:
Clock-domain (clk) responder for the debug-module OCI memory command strobes. It decodes jdo and the take_action_ocimem_a, take_no_action_ocimem_a and take_action_ocimem_b pulses, and performs address-load, read and write operations on an on-chip debug RAM. It returns MonDReg, monitor_ready, monitor_error and resetlatch to the JTAG-side shift register for capture. It also arbitrates a CPU-side slave port onto the same single-port RAM.

Parameters:
ADDR_W, 8, debug RAM address width; legal range 1..8; RAM depth is 2^ADDR_W words of 32 bits.

Ports:
clk  in  1  system clock
jrst_n  in  1  reset; asynchronous, active-low
jdo  in  38  command/data word latched by the JTAG side
take_action_ocimem_a  in  1  one-cycle pulse: address load
take_no_action_ocimem_a  in  1  one-cycle pulse: read at current address
take_action_ocimem_b  in  1  one-cycle pulse: write at current address
cpu_reset_seen  in  1  level: CPU reset occurred
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_readdata  out  32  CPU read data; fixed latency 1
avs_waitrequest  out  1  CPU stall
MonDReg  out  32  monitor data to JTAG capture
monitor_ready  out  1  last JTAG command complete
monitor_error  out  1  sticky command-collision error
resetlatch  out  1  sticky CPU-reset indicator
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: MonAReg (internal address register) = 0, MonDReg = 0, monitor_ready = 0, monitor_error = 0, resetlatch = 0, state = IDLE, avs_waitrequest = 0, busy = 0. RAM contents are not reset.
- Field map:
  - Address = jdo[25+ADDR_W:26].
  - Clear-resetlatch flag = jdo[24].
  - Write data = jdo[34:3].
- FSM states: IDLE and RD.
- Strobe accepted in IDLE, cycle T:
  - ocimem_a: MonAReg <= address field; monitor_error <= 0; monitor_ready <= 1; resetlatch <= 0 if jdo[24]. State stays IDLE.
  - no_action_a: RAM read at MonAReg is issued at edge T; MonAReg <= MonAReg+1; monitor_ready <= 0; state -> RD. In RD (cycle T+1): MonDReg <= RAM q; monitor_ready <= 1; state -> IDLE. MonDReg is valid from cycle T+2.
  - ocimem_b: RAM[MonAReg] <= write data at edge T; MonAReg <= MonAReg+1; monitor_ready <= 1 after edge T (single cycle).
- Address increment wraps: 2^ADDR_W-1 -> 0.
- Strobe arriving while in RD: command is dropped, monitor_error <= 1, the in-flight read still completes. The error stays set until the next accepted ocimem_a.
- More than one strobe in the same cycle (illegal): priority ocimem_b > no_action_a > ocimem_a; monitor_error <= 1.
- resetlatch is set while cpu_reset_seen = 1. Set wins over a simultaneous jdo[24] clear.
- CPU port:
  - avs_waitrequest = (state != IDLE) | any strobe this cycle (combinational).
  - A request is accepted when avs_waitrequest = 0. An accepted write updates the RAM at that edge.
  - An accepted read presents avs_readdata = RAM q in the next cycle.
  - avs_read and avs_write together: write wins.
  - JTAG strobes always take priority over the CPU port.
- Reset asserted mid-RD: FSM returns to IDLE, the read is abandoned, all outputs return to reset values.

Optional Feature:
OCIMEM_WRITE_PROTECT_EN
- Defined: addresses with MSB = 1 (upper half) are read-only from JTAG. An ocimem_b write to that region is suppressed, sets monitor_error = 1 and still increments MonAReg. CPU writes to the region are unaffected.
- Undefined: all addresses are writable from both ports.

Decomposition:
- Package cpu_1_ocimem_pkg holds:
  - FSM state enum (IDLE, RD).
  - Field position constants: ADDR_LSB = 26, WDATA_MSB = 34, WDATA_LSB = 3, RSTCLR_BIT = 24.
  - MAX_ADDR_W = 8.
- Sub-module cpu_1_ocimem_ram: single-port synchronous RAM, 2^ADDR_W x 32, registered address, one-cycle read.

Test Plan:
- Reset, then ocimem_a with address 0x10 -> MonAReg = 0x10, monitor_ready = 1, monitor_error = 0.
- ocimem_b with data 0xDEADBEEF, then ocimem_a 0x10, then no_action_a -> MonDReg = 0xDEADBEEF at T+2, MonAReg = 0x11.
- ADDR_W = 8, MonAReg = 0xFF, ocimem_b -> RAM[0xFF] written, MonAReg = 0x00.
- no_action_a at T, ocimem_b at T+1 -> monitor_error = 1, RAM unchanged, MonDReg correct. Next ocimem_a clears the error.
- CPU avs_read of address 0x20 issued in the same cycle as a strobe -> avs_waitrequest = 1. Read is accepted once the FSM returns to IDLE; readdata valid one cycle after acceptance.
- cpu_reset_seen pulse -> resetlatch = 1. ocimem_a with jdo[24] = 1 -> resetlatch = 0. With OCIMEM_WRITE_PROTECT_EN, ocimem_b to 0x80 -> monitor_error = 1, RAM[0x80] unchanged.
